// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: comma symbol, default lock threshold and the
// byte-alignment state encoding used by the serial receive path.
package pcie_phy_pkg;

    // Comma / idle symbol emitted by the ptos serializer when it has no data.
    localparam logic [7:0] COM_SYM = 8'hBC;

    // Consecutive byte-aligned commas needed before the receiver trusts its phase.
    localparam int LOCK_BC_DEFAULT = 4;

    // Byte-alignment state machine encoding.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,  // sliding search for a comma at any bit offset
        ALIGN  = 2'd1,  // phase chosen, confirming commas on byte boundaries
        ACTIVE = 2'd2   // locked, emitting one byte every 8 clocks
    } align_state_t;

endpackage

// File: rtl/stop_aligner.sv
// Serial-to-parallel receive stage. Shifts in one bit per clk (MSB first),
// finds comma alignment at any bit offset, confirms it over LOCK_BC
// consecutive aligned commas and then emits one byte per 8 clocks with a
// valid flag that is low for idle commas. Lock is sticky until reset.
module stop_aligner
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0] COM     = COM_SYM,
    parameter int         LOCK_BC = LOCK_BC_DEFAULT   // legal range 2..15
) (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active-low
    input  logic       in,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       byte_strb,
    output logic       active
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_BC);

    logic [7:0]   shreg;
    logic [2:0]   bit_cnt;
    logic [3:0]   bc_cnt;
    logic [3:0]   bc_next;
    logic         shreg_is_com;
    logic         at_boundary;
    align_state_t state;

    assign shreg_is_com = (shreg == COM);
    assign at_boundary  = (bit_cnt == 3'd7);
    assign bc_next      = bc_cnt + 4'd1;

    // Serial shift register, newest bit enters at the LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= 8'h00;
        end else begin
            // NOTE: registers are written with <= so every block samples the
            // pre-edge value of shreg; blocking here would race the FSM below.
            shreg <= {shreg[6:0], in};
        end
    end

    // Alignment FSM, bit/comma counters and registered byte outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            bit_cnt   <= 3'd0;
            bc_cnt    <= 4'd0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            byte_strb <= 1'b0;
            active    <= 1'b0;
        end else begin
            // Free-running phase counter; only meaningful outside HUNT.
            bit_cnt   <= bit_cnt + 3'd1;
            byte_strb <= 1'b0;

            case (state)
                HUNT: begin
                    // Sliding compare: a comma at any offset fixes the phase so
                    // that bit_cnt reaches 7 exactly when the next byte is complete.
                    if (shreg_is_com) begin
                        bit_cnt <= 3'd0;
                        bc_cnt  <= 4'd1;
                        state   <= ALIGN;
                    end
                end

                ALIGN: begin
                    // Off-boundary commas are ignored; only boundary bytes count.
                    if (at_boundary) begin
                        if (shreg_is_com) begin
                            bc_cnt <= bc_next;
                            if (bc_next == LOCK_CNT) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= 4'd0;
                            state  <= HUNT;
                        end
                    end
                end

                ACTIVE: begin
                    // Publish each completed byte; commas go out flagged invalid.
                    if (at_boundary) begin
                        out       <= shreg;
                        out_valid <= !shreg_is_com;
                        byte_strb <= 1'b1;
                    end
                end

                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stop_aligner.sv
// Directed bench for stop_aligner: reset behaviour, lock at zero and random
// bit offsets, idle interleave, broken alignment and asynchronous mid-stream reset.
module tb_stop_aligner;
    import pcie_phy_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       in    = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       byte_strb;
    logic       active;

    int checks = 0;
    int errors = 0;

    stop_aligner #(
        .COM     (COM_SYM),
        .LOCK_BC (LOCK_BC_DEFAULT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .byte_strb (byte_strb),
        .active    (active)
    );

    always #5 clk = ~clk;

    // Edge counter: after the n-th posedge, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log and lock-rise time, sampled on the falling edge.
    typedef struct {
        int         t;
        logic [7:0] d;
        logic       v;
    } strb_rec_t;

    strb_rec_t strb_q[$];
    int        act_rise = -1;
    logic      prev_act = 1'b0;

    always @(negedge clk) begin
        if (byte_strb === 1'b1) strb_q.push_back('{cyc, out, out_valid});
        if (active === 1'b1 && !prev_act) act_rise <= cyc;
        prev_act <= (active === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_strb(input string tag, input int idx, input int exp_t,
                              input logic [7:0] exp_d, input logic exp_v);
        check({tag, "_present"}, 32'(strb_q.size() > idx), 32'd1);
        if (idx < strb_q.size()) begin
            check({tag, "_time"},  strb_q[idx].t, exp_t);
            check({tag, "_data"},  32'(strb_q[idx].d), 32'(exp_d));
            check({tag, "_valid"}, 32'(strb_q[idx].v), 32'(exp_v));
        end
    endtask

    // Drive one bit away from the edge, then wait for the edge that samples it.
    task automatic tick(input logic b);
        in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick(1'($urandom));
        tick(1'($urandom));
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int e4;
        int e_a;
        int e_b;

        // 1. Reset held for 3 clocks with random input bits.
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom));
            check("rst_out",       32'(out),       32'h00);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_byte_strb", 32'(byte_strb), 32'd0);
            check("rst_active",    32'(active),    32'd0);
        end
        reset = 1'b1;

        // 2 + 4. Zero-offset lock, then EE / BC / CC / BC interleave.
        base = strb_q.size();
        repeat (4) send_byte(COM_SYM);
        e4 = cyc;
        check("t2_pre_active", 32'(active), 32'd0);
        check("t2_pre_strb",   strb_q.size(), base);
        send_byte(8'hEE);
        send_byte(COM_SYM);
        send_byte(8'hCC);
        send_byte(COM_SYM);
        send_byte(8'h00);
        check("t2_act_rise", act_rise, e4 + 1);
        check("t4_count",    strb_q.size(), base + 4);
        check_strb("t4_b0", base + 0, e4 + 9,  8'hEE, 1'b1);
        check_strb("t4_b1", base + 1, e4 + 17, 8'hBC, 1'b0);
        check_strb("t4_b2", base + 2, e4 + 25, 8'hCC, 1'b1);
        check_strb("t4_b3", base + 3, e4 + 33, 8'hBC, 1'b0);
        check("t4_active", 32'(active), 32'd1);

        // 3. Lock at an arbitrary bit offset.
        pulse_reset();
        check("t3_rst_active", 32'(active), 32'd0);
        base = strb_q.size();
        repeat (3) tick(1'($urandom));
        repeat (4) send_byte(COM_SYM);
        e4 = cyc;
        send_byte(8'hEE);
        e_a = cyc;
        send_byte(8'hCC);
        e_b = cyc;
        send_byte(8'h00);
        check("t3_act_rise", act_rise, e4 + 1);
        check("t3_count",    strb_q.size(), base + 2);
        check_strb("t3_ee", base + 0, e_a + 1, 8'hEE, 1'b1);
        check_strb("t3_cc", base + 1, e_b + 1, 8'hCC, 1'b1);

        // 5. Broken alignment: two commas, a 55, then a fresh run of four.
        pulse_reset();
        base = strb_q.size();
        repeat (2) send_byte(COM_SYM);
        send_byte(8'h55);
        repeat (4) send_byte(COM_SYM);
        e4 = cyc;
        check("t5_no_early_lock", 32'(active), 32'd0);
        check("t5_no_early_strb", strb_q.size(), base);
        send_byte(8'hA5);
        e_a = cyc;
        send_byte(8'h00);
        check("t5_act_rise", act_rise, e4 + 1);
        check("t5_count",    strb_q.size(), base + 1);
        check_strb("t5_a5", base, e_a + 1, 8'hA5, 1'b1);

        // 6. Asynchronous reset during the 4th bit of a data byte.
        pulse_reset();
        repeat (4) send_byte(COM_SYM);
        send_byte(8'hEE);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        check("t6_pre_out",    32'(out),    32'hEE);
        check("t6_pre_active", 32'(active), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_out",       32'(out),       32'h00);
        check("t6_async_out_valid", 32'(out_valid), 32'd0);
        check("t6_async_byte_strb", 32'(byte_strb), 32'd0);
        check("t6_async_active",    32'(active),    32'd0);
        tick(1'b1);
        tick(1'b1);
        reset = 1'b1;
        base = strb_q.size();
        repeat (3) send_byte(COM_SYM);
        check("t6_relock_active", 32'(active), 32'd0);
        check("t6_relock_strb",   strb_q.size(), base);
        send_byte(COM_SYM);
        e4 = cyc;
        send_byte(8'h5A);
        e_a = cyc;
        send_byte(8'h00);
        check("t6_act_rise", act_rise, e4 + 1);
        check("t6_count",    strb_q.size(), base + 1);
        check_strb("t6_5a", base, e_a + 1, 8'h5A, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
